// File: rtl/neuraedge_noc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : neuraedge_noc_pkg
// Purpose : Shared NoC flit layout, port indices and arbiter state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package neuraedge_noc_pkg;

    localparam int NOC_FLIT_W_DEFAULT = 64;
    localparam int FLIT_HEAD_BIT      = NOC_FLIT_W_DEFAULT - 1;
    localparam int FLIT_TAIL_BIT      = NOC_FLIT_W_DEFAULT - 2;
    localparam int LOCAL_PORT         = 4;

    typedef logic [NOC_FLIT_W_DEFAULT-1:0] flit_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/noc_skid_fifo2.sv
`default_nettype none
// ============================================================================
// Module  : noc_skid_fifo2
// Purpose : Two-entry valid/ready buffer exposing its occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module noc_skid_fifo2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // A push into a full buffer is dropped; the producer gates on o_count.
    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = o_valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/neuraedge_tile_inject_arb.sv
`default_nettype none
// ============================================================================
// Module  : neuraedge_tile_inject_arb
// Purpose : Wormhole round-robin arbiter for the tile router LOCAL injection port.
// Revision: 1.0 - initial release
// ============================================================================
module neuraedge_tile_inject_arb
    import neuraedge_noc_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int NOC_FLIT_W = NOC_FLIT_W_DEFAULT,
    parameter int STALL_MAX  = 255,
    localparam int IDX_W     = $clog2(N_REQ),
    localparam int CNT_W     = $clog2(STALL_MAX + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_REQ-1:0][NOC_FLIT_W-1:0] i_req_flit,
    input  logic [N_REQ-1:0]                 i_req_valid,
    output logic [N_REQ-1:0]                 o_req_ready,
    output logic [NOC_FLIT_W-1:0]            o_out_flit,
    output logic                             o_out_valid,
    input  logic                             i_out_ready,
    output logic [IDX_W-1:0]                 o_grant_id,
    output logic                             o_locked,
    output logic                             o_err_proto,
    output logic                             o_err_stall
);

    localparam logic [CNT_W-1:0] c_stall_max  = CNT_W'(STALL_MAX);
    localparam logic [CNT_W-1:0] c_stall_last = CNT_W'(STALL_MAX - 1);

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic                  r_run;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_rr_ptr_nxt;
    logic [IDX_W-1:0]      r_grant_id;
    logic [IDX_W-1:0]      w_grant_nxt;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      w_stall_nxt;
    logic [N_REQ-1:0]      w_head;
    logic [N_REQ-1:0]      w_cand;
    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;
    logic [IDX_W-1:0]      w_sel;
    logic                  w_push;
    logic [NOC_FLIT_W-1:0] w_push_flit;
    logic [1:0]            w_count;
    logic                  w_space;

    // Returns {found, index} of the first set candidate at or after ptr, wrapping.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] cand,
                                               input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = IDX_W'((int'(ptr) + k) % N_REQ);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return IDX_W'((int'(idx) + 1) % N_REQ);
    endfunction

    for (genvar g = 0; g < N_REQ; g++) begin : g_head
        assign w_head[g] = i_req_flit[g][NOC_FLIT_W-1];
    end

    assign w_cand  = i_req_valid & w_head;
    assign w_space = (w_count < 2'd2);

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_grant_nxt  = r_grant_id;
        w_stall_nxt  = r_stall_cnt;
        w_sel        = r_grant_id;
        w_push       = 1'b0;
        o_req_ready  = '0;
        o_err_proto  = 1'b0;
        o_err_stall  = 1'b0;
        {w_found, w_winner} = rr_pick(w_cand, r_rr_ptr);

        // r_run holds everything quiet for the first cycle after reset release.
        if (r_run) begin
            case (r_state)
                ST_IDLE: begin
                    w_stall_nxt = '0;
                    if (w_found) begin
                        w_sel                 = w_winner;
                        o_req_ready[w_winner] = w_space;
                        if (w_space) begin
                            w_push      = 1'b1;
                            w_grant_nxt = w_winner;
                            if (i_req_flit[w_winner][NOC_FLIT_W-2]) begin
                                w_rr_ptr_nxt = next_idx(w_winner);
                            end else begin
                                w_state_nxt = ST_LOCKED;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    o_req_ready[r_grant_id] = w_space;
                    if (i_req_valid[r_grant_id] && w_space) begin
                        w_push      = 1'b1;
                        w_stall_nxt = '0;
                        if (i_req_flit[r_grant_id][NOC_FLIT_W-2]) begin
                            w_state_nxt  = ST_IDLE;
                            w_rr_ptr_nxt = next_idx(r_grant_id);
                        end
                    end else if (!i_req_valid[r_grant_id]) begin
                        // Owner valid against a full buffer is backpressure, not a stall.
                        if (r_stall_cnt != c_stall_max) begin
                            w_stall_nxt = r_stall_cnt + 1'b1;
                            o_err_stall = (r_stall_cnt == c_stall_last);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase

            for (int i = 0; i < N_REQ; i++) begin
                if (i_req_valid[i] && !w_head[i] &&
                    !((r_state == ST_LOCKED) && (r_grant_id == IDX_W'(i)))) begin
                    o_err_proto = 1'b1;
                end
            end
        end
    end

    assign w_push_flit = i_req_flit[w_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_run       <= 1'b1;
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_nxt;
            r_stall_cnt <= w_stall_nxt;
        end
    end

    noc_skid_fifo2 #(
        .WIDTH (NOC_FLIT_W)
    ) u_out_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_flit),
        .o_data      (o_out_flit),
        .o_valid     (o_out_valid),
        .i_ready     (i_out_ready),
        .o_count     (w_count)
    );

    assign o_grant_id = r_grant_id;
    assign o_locked   = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_neuraedge_tile_inject_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_neuraedge_tile_inject_arb
// Purpose : Self-checking bench for the tile injection arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_neuraedge_tile_inject_arb;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SM = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [N-1:0][W-1:0] req_flit;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [W-1:0]        out_flit;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          grant_id;
    logic                locked;
    logic                err_proto;
    logic                err_stall;

    neuraedge_tile_inject_arb #(
        .N_REQ      (N),
        .NOC_FLIT_W (W),
        .STALL_MAX  (SM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_flit  (req_flit),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .o_out_flit  (out_flit),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_grant_id  (grant_id),
        .o_locked    (locked),
        .o_err_proto (err_proto),
        .o_err_stall (err_stall)
    );

    // Flit layout used here: [15]=HEAD [14]=TAIL [13:12]=source [11:0]=sequence.
    typedef struct {
        logic [3:0] en;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        int         src;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         seq   = 0;
    logic [W-1:0] tx_q [N][$];
    logic [W-1:0] out_log [$];
    logic [N-1:0] en;
    logic         ordy;
    logic         s_proto, s_stall, s_locked;

    // Transaction-level reference: buffered flits, current packet owner, rr pointer.
    logic [W-1:0] m_q [$];
    int           m_owner, m_ptr, m_grant, m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s @cyc %0d: wait bound expired", name, cyc);
    endtask

    task automatic add_pkt(input int src, input int len);
        logic [W-1:0] f;
        for (int k = 0; k < len; k++) begin
            f        = '0;
            f[15]    = (k == 0);
            f[14]    = (k == len - 1);
            f[13:12] = src[1:0];
            f[11:0]  = seq[11:0];
            seq++;
            tx_q[src].push_back(f);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_owner = -1;
        m_ptr   = 0;
        m_grant = 0;
        m_stall = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] e_rdy;
        logic         e_proto, e_stall, e_ov, e_lock, acc;
        logic [W-1:0] e_flit, a_flit;
        logic [1:0]   e_grant;
        int           win, i;
        bit           space;
        e_rdy   = '0;
        e_proto = 1'b0;
        e_stall = 1'b0;
        acc     = 1'b0;
        win     = -1;
        space   = (m_q.size() < 2);
        e_ov    = (m_q.size() > 0);
        e_flit  = e_ov ? m_q[0] : '0;
        e_lock  = (m_owner >= 0);
        e_grant = m_grant[1:0];
        if (m_owner >= 0) begin
            if (space) e_rdy[m_owner] = 1'b1;
            if (!req_valid[m_owner] && m_stall == SM - 1) e_stall = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (win < 0 && req_valid[i] && req_flit[i][W-1]) win = i;
            end
            if (win >= 0 && space) e_rdy[win] = 1'b1;
        end
        for (int r = 0; r < N; r++) begin
            if (req_valid[r] && !req_flit[r][W-1] && r != m_owner) e_proto = 1'b1;
        end
        a_flit = e_ov ? out_flit : '0;
        check("cycle", {req_ready, out_valid, a_flit, locked, grant_id, err_proto, err_stall},
                       {e_rdy, e_ov, e_flit, e_lock, e_grant, e_proto, e_stall});
        if (e_ov && ordy) void'(m_q.pop_front());
        for (int r = 0; r < N; r++) begin
            if (e_rdy[r] && req_valid[r]) begin
                acc = 1'b1;
                m_q.push_back(req_flit[r]);
                m_stall = 0;
                if (m_owner < 0) begin
                    m_grant = r;
                    if (req_flit[r][W-2]) m_ptr = (r + 1) % N;
                    else                  m_owner = r;
                end else if (req_flit[r][W-2]) begin
                    m_owner = -1;
                    m_ptr   = (r + 1) % N;
                end
            end
        end
        if (!acc && m_owner >= 0 && !req_valid[m_owner] && m_stall < SM) m_stall++;
    endtask

    task automatic cycle_eval();
        for (int r = 0; r < N; r++) begin
            req_valid[r] = en[r] && (tx_q[r].size() > 0);
            req_flit[r]  = (tx_q[r].size() > 0) ? tx_q[r][0] : '0;
        end
        out_ready = ordy;
        #1;
        model_step();
        s_proto  = err_proto;
        s_stall  = err_stall;
        s_locked = locked;
        if (out_valid && out_ready) out_log.push_back(out_flit);
        for (int r = 0; r < N; r++) begin
            if (req_valid[r] && req_ready[r]) void'(tx_q[r].pop_front());
        end
    endtask

    task automatic cycle_adv();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc > 20000) begin
            fail_now("global_timeout");
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "run aborted");
        end
    endtask

    task automatic drain();
        int k;
        en   = '0;
        ordy = 1'b1;
        k    = 0;
        while ((m_q.size() > 0 || out_valid) && k < 10) begin
            cycle_eval();
            cycle_adv();
            k++;
        end
        if (k >= 10) fail_now("drain");
    endtask

    vec_t tbl [14];
    int   worm_src [5];
    int   k, pulses, pulse_at, n_exp, n_proto;
    bit   found, lock_all;
    logic [W-1:0] bodyf;

    initial begin
        tbl[0]  = '{4'hF, 1'b1, 4'b0001, 1'b0, -1};
        tbl[1]  = '{4'hF, 1'b1, 4'b0010, 1'b1, 0};
        tbl[2]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 1};
        tbl[3]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 2};
        tbl[4]  = '{4'hF, 1'b1, 4'b0001, 1'b1, 3};
        tbl[5]  = '{4'hF, 1'b0, 4'b0010, 1'b1, 0};
        tbl[6]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 0};
        tbl[7]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 0};
        tbl[8]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 0};
        tbl[9]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 0};
        tbl[10] = '{4'hF, 1'b1, 4'b0000, 1'b1, 0};
        tbl[11] = '{4'hF, 1'b1, 4'b0100, 1'b1, 1};
        tbl[12] = '{4'hF, 1'b1, 4'b1000, 1'b1, 2};
        tbl[13] = '{4'hF, 1'b1, 4'b0001, 1'b1, 3};
        worm_src = '{2, 2, 2, 2, 1};

        // Reset with every requester presenting a head.
        rst_n     = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < N; r++) begin
            req_valid[r] = 1'b1;
            req_flit[r]  = 16'hC000 | (16'(r) << 12);
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {req_ready, out_valid, out_flit, grant_id, locked, err_proto, err_stall}, 64'd0);
        rst_n = 1'b1;
        found = 1'b0;
        for (int j = 0; j < 6 && !found; j++) begin
            #1;
            if (req_ready != '0) begin
                found = 1'b1;
                check("first_grant", {60'd0, req_ready}, 64'b0001);
            end
            @(posedge clk);
            #1;
        end
        if (!found) fail_now("first_grant");

        // Clean restart for the modelled part of the run.
        req_valid = '0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Fairness and backpressure table.
        for (int r = 0; r < N; r++) for (int p = 0; p < 5; p++) add_pkt(r, 1);
        for (int i = 0; i < 14; i++) begin
            en   = tbl[i].en;
            ordy = tbl[i].ordy;
            cycle_eval();
            check($sformatf("vec%0d", i),
                  {req_ready, out_valid, (out_valid ? 32'(out_flit[13:12]) : 32'hFFFF_FFFF)},
                  {tbl[i].rdy, tbl[i].ov, 32'(tbl[i].src)});
            cycle_adv();
        end
        for (int r = 0; r < N; r++) tx_q[r].delete();
        drain();

        // Wormhole lock: requester 1 waits behind a 4-flit packet from 2.
        out_log.delete();
        add_pkt(2, 4);
        add_pkt(1, 1);
        en = 4'b0100;
        cycle_eval();
        cycle_adv();
        en = 4'b0110;
        k  = 0;
        while (out_log.size() < 5 && k < 30) begin
            cycle_eval();
            cycle_adv();
            k++;
        end
        if (out_log.size() < 5) fail_now("worm_order");
        else for (int j = 0; j < 5; j++)
            check($sformatf("worm_src%0d", j), 64'(out_log[j][13:12]), 64'(worm_src[j]));
        drain();

        // Protocol error: requester 1 shows a body flit while not owner.
        out_log.delete();
        bodyf = 16'h1ABC;
        tx_q[1].push_back(bodyf);
        for (int p = 0; p < 3; p++) add_pkt(0, 1);
        en      = 4'b0011;
        n_proto = 0;
        for (int j = 0; j < 6; j++) begin
            cycle_eval();
            if (s_proto) n_proto++;
            cycle_adv();
        end
        check("proto_pulses", 64'(n_proto), 64'd6);
        check("proto_not_taken", 64'(tx_q[1].size()), 64'd1);
        tx_q[1].delete();
        drain();
        check("proto_others_ok", 64'(out_log.size()), 64'd3);

        // Stall: owner idles 10 cycles mid-packet.
        out_log.delete();
        add_pkt(3, 3);
        en = 4'b1000;
        k  = 0;
        while (tx_q[3].size() > 2 && k < 10) begin
            cycle_eval();
            cycle_adv();
            k++;
        end
        if (k >= 10) fail_now("stall_head");
        en       = '0;
        pulses   = 0;
        pulse_at = -1;
        lock_all = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cycle_eval();
            if (s_stall) begin
                pulses++;
                pulse_at = j;
            end
            if (!s_locked) lock_all = 1'b0;
            cycle_adv();
        end
        check("stall_pulses", 64'(pulses), 64'd1);
        check("stall_pulse_cycle", 64'(pulse_at), 64'd7);
        check("stall_lock_held", 64'(lock_all), 64'd1);
        en = 4'b1000;
        k  = 0;
        while (out_log.size() < 3 && k < 20) begin
            cycle_eval();
            cycle_adv();
            k++;
        end
        check("stall_completes", 64'(out_log.size()), 64'd3);
        drain();

        // Randomized traffic with random gaps and backpressure.
        out_log.delete();
        n_exp = 0;
        for (int r = 0; r < N; r++) begin
            for (int p = 0; p < 10; p++) begin
                k = $urandom_range(1, 4);
                add_pkt(r, k);
                n_exp += k;
            end
        end
        k = 0;
        while ((tx_q[0].size() + tx_q[1].size() + tx_q[2].size() + tx_q[3].size() +
                m_q.size()) > 0 && k < 4000) begin
            for (int r = 0; r < N; r++) en[r] = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 9) < 7);
            cycle_eval();
            cycle_adv();
            k++;
        end
        if (k >= 4000) fail_now("random_drain");
        check("random_flit_count", 64'(out_log.size()), 64'(n_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
